// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and lane helpers for the load/store unit
package lsu_pkg;

   typedef enum logic [2:0] {
      LS_B  = 3'b000,
      LS_H  = 3'b001,
      LS_W  = 3'b010,
      LS_BU = 3'b100,
      LS_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      FLT_NONE     = 2'b00,
      FLT_MISALIGN = 2'b01,
      FLT_RANGE    = 2'b10,
      FLT_ILLEGAL  = 2'b11
   } fault_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_RESP
   } state_e;

   // Store byte enables; misaligned requests never reach here, so the shift cannot overflow.
   function automatic logic [3:0] byte_enable(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         LS_B:    byte_enable = 4'b0001 << off;
         LS_H:    byte_enable = 4'b0011 << off;
         default: byte_enable = 4'b1111;
      endcase
   endfunction

   // Replicate the store operand so every byte lane carries the right value.
   function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] d);
      case (funct3)
         LS_B:    store_data = {4{d[7:0]}};
         LS_H:    store_data = {2{d[15:0]}};
         default: store_data = d;
      endcase
   endfunction

   // Move the addressed byte lane down to bit 0.
   function automatic logic [31:0] lane_select(input logic [31:0] rdata, input logic [1:0] off);
      lane_select = rdata >> {off, 3'b000};
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and extends the loaded lane
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] lane;

   // Shift the addressed lane down, then sign- or zero-extend by access size.
   always_comb begin
      lane = lane_select(rdata, offset);
      case (funct3)
         LS_B:    data = {{24{lane[7]}}, lane[7:0]};
         LS_BU:   data = {24'd0, lane[7:0]};
         LS_H:    data = {{16{lane[15]}}, lane[15:0]};
         LS_HU:   data = {16'd0, lane[15:0]};
         default: data = lane;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit driving the one-cycle-latency data memory
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DMEM_SIZE = 2**15,
   parameter int ADD_WIDTH = $clog2(DMEM_SIZE >> 2),
   parameter int IMM_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [4:0]           req_rd,
   input  logic [XLEN-1:0]      rs1,
   input  logic [IMM_WIDTH-1:0] imm,
   input  logic [XLEN-1:0]      rs2,
   output logic                 rsp_valid,
   output logic [XLEN-1:0]      rsp_data,
   output logic [4:0]           rsp_rd,
   output logic [1:0]           rsp_fault,
   output logic [ADD_WIDTH-1:0] mem_addr,
   output logic                 mem_go,
   output logic                 mem_we,
   output logic [3:0]           mem_byteen,
   output logic [XLEN-1:0]      mem_wdata,
   input  logic [XLEN-1:0]      mem_rdata
);

   state_e               state, state_nxt;
   logic [XLEN-1:0]      ea;
   fault_e               fault_d;
   logic                 illegal, misalign;
   logic                 accept, issue, resp;

   logic [ADD_WIDTH+1:0] ea_q;
   logic [2:0]           funct3_q;
   logic                 we_q;
   logic [4:0]           rd_q;
   logic [XLEN-1:0]      rs2_q;
   logic [XLEN-1:0]      load_q;
   logic [XLEN-1:0]      load_ext;
   fault_e               fault_q;

   assign ea        = rs1 + {{(XLEN-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign issue     = (state == ST_ISSUE);
   assign resp      = (state == ST_RESP);

   // Classify the incoming request: illegal beats misaligned beats out-of-range.
   always_comb begin
      illegal  = 1'b1;
      misalign = 1'b0;
      case (req_funct3)
         LS_B:    illegal = 1'b0;
         LS_BU:   illegal = req_we;
         LS_H:    begin illegal = 1'b0;   misalign = ea[0];      end
         LS_HU:   begin illegal = req_we; misalign = ea[0];      end
         LS_W:    begin illegal = 1'b0;   misalign = |ea[1:0];   end
         default: illegal = 1'b1;
      endcase
      if (illegal)
         fault_d = FLT_ILLEGAL;
      else if (misalign)
         fault_d = FLT_MISALIGN;
      else if (ea >= XLEN'(DMEM_SIZE))
         fault_d = FLT_RANGE;
      else
         fault_d = FLT_NONE;
   end

   // State register; reset abandons any in-flight access or response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state: faults skip the memory, stores skip the capture cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (accept) state_nxt = (fault_d == FLT_NONE) ? ST_ISSUE : ST_RESP;
         ST_ISSUE:   state_nxt = we_q ? ST_RESP : ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_RESP;
         ST_RESP:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Request fields latch at accept; load data latches in the capture cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ea_q     <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         rd_q     <= '0;
         rs2_q    <= '0;
         load_q   <= '0;
         fault_q  <= FLT_NONE;
      end else if (accept) begin
         ea_q     <= ea[ADD_WIDTH+1:0];
         funct3_q <= req_funct3;
         we_q     <= req_we;
         rd_q     <= req_rd;
         rs2_q    <= rs2;
         load_q   <= '0;
         fault_q  <= fault_d;
      end else if (state == ST_CAPTURE) begin
         load_q   <= load_ext;
      end
   end

   lsu_load_align u_align (
      .rdata  (mem_rdata),
      .offset (ea_q[1:0]),
      .funct3 (funct3_q),
      .data   (load_ext)
   );

   assign mem_go     = issue;
   assign mem_we     = issue && we_q;
   assign mem_addr   = issue ? ea_q[ADD_WIDTH+1:2] : '0;
   assign mem_byteen = issue ? (we_q ? byte_enable(funct3_q, ea_q[1:0]) : 4'b1111) : 4'b0000;
   assign mem_wdata  = (issue && we_q) ? store_data(funct3_q, rs2_q) : '0;

   assign rsp_valid  = resp;
   assign rsp_data   = resp ? load_q : '0;
   assign rsp_rd     = resp ? rd_q : '0;
   assign rsp_fault  = resp ? fault_q : FLT_NONE;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit for the RISC-V core; it is the initiator on the data-memory port.
- It accepts one load or store from the execute stage and computes the effective address.
- It checks alignment and range, generates byte enables and replicated write data, and drives the one-cycle-latency on-chip data memory.
- It sign- or zero-extends load data and returns a single-cycle response to the pipeline.

Parameters:
XLEN, 32, data/address width
DMEM_SIZE, 2**15, data memory size in bytes
ADD_WIDTH, $clog2(DMEM_SIZE>>2), word-address width (13 at default)
IMM_WIDTH, 12, signed immediate width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  pipeline presents a request
req_ready  out  1  LSU can accept; high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_rd  in  5  load destination tag
rs1  in  XLEN  base register value
imm  in  IMM_WIDTH  signed offset
rs2  in  XLEN  store data
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  XLEN  extended load data; 0 for stores and faults
rsp_rd  out  5  tag echoed from the request
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
mem_addr  out  ADD_WIDTH  word address, ea[ADD_WIDTH+1:2]
mem_go  out  1  memory chipselect/clken
mem_we  out  1  memory write
mem_byteen  out  4  byte enables
mem_wdata  out  XLEN  write data
mem_rdata  in  XLEN  read data, valid the cycle after mem_go

Behaviour:
- Reset: state=IDLE. All outputs 0 except req_ready=1. Reset takes effect immediately (asynchronous). mem_go drops in the same cycle.
- ea = rs1 + sign-extended imm, computed modulo 2^32.
- Request is accepted on a clock edge where req_valid && req_ready. All request fields are registered at accept.
- Fault check at accept, highest priority first:
  - 11 illegal: funct3 in {011,110,111}, or a store with funct3 100/101.
  - 01 misaligned: H/HU with ea[0]=1, or W with ea[1:0]!=0.
  - 10 out of range: ea >= DMEM_SIZE.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE -> RESP when the request faults. No memory access occurs.
  - IDLE -> ISSUE on a legal accept.
  - ISSUE -> RESP for a store.
  - ISSUE -> CAPTURE for a load.
  - CAPTURE -> RESP.
  - RESP -> IDLE.
- ISSUE cycle (T+1): mem_go=1, mem_we=req_we, mem_addr=ea[ADD_WIDTH+1:2].
  - Store enables: SB 0001<<ea[1:0]; SH 0011<<ea[1:0]; SW 1111.
  - Store data: SB rs2[7:0] replicated x4; SH rs2[15:0] replicated x2; SW rs2.
  - Loads: mem_byteen=1111, mem_wdata=0.
  - Memory outputs are 0 in every state other than ISSUE.
- CAPTURE cycle (T+2): mem_rdata is registered. The extracted lane is rdata >> (8*ea[1:0]).
  - B and H are sign-extended; BU and HU are zero-extended; W passes through.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rd and rsp_fault are valid.
  - Store response at T+2, load response at T+3, fault response at T+1.
  - The pipeline must consume the response; rsp has no backpressure.
- req_valid outside IDLE is ignored (req_ready=0). Back-to-back requests are accepted from the next IDLE cycle.
- Reset during ISSUE:
  - A store whose ISSUE edge has not yet occurred is not performed.
  - An in-flight load or store response is discarded and is never pulsed after reset release.

Decomposition:
- Package lsu_pkg holds:
  - funct3 enum (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - fault enum (FLT_NONE, FLT_MISALIGN, FLT_RANGE, FLT_ILLEGAL);
  - FSM state enum;
  - byte-enable and lane-select helper functions.
- One combinational sub-module, lsu_load_align: inputs rdata, offset[1:0], funct3; output extended data.

Test Plan:
- SW rs1=0x100 imm=4 rs2=0xDEADBEEF -> T+1 mem_go=1, mem_we=1, mem_addr=0x41, byteen=1111, wdata=0xDEADBEEF; T+2 rsp_valid=1, fault=00.
- SB rs1=0x103 imm=0 rs2=0x123456A5 -> byteen=1000, wdata=0xA5A5A5A5; SH ea=0x102 rs2=0xBEEF -> byteen=1100, wdata=0xBEEFBEEF.
- Memory word at 0x200 = 0x80FF7F01, each load checked at T+3:
  - LB 0x202 -> 0xFFFFFFFF; LBU 0x203 -> 0x00000080;
  - LH 0x202 -> 0xFFFF80FF; LHU 0x202 -> 0x000080FF;
  - LW rs1=0x204 imm=0xFFC -> 0x80FF7F01, with mem_addr=0x80; rsp_rd echoes the tag.
- LW ea=0x101 -> T+1 rsp_valid with fault=01, mem_go never asserted; SW ea=0x8000 -> fault=10; funct3=011 -> fault=11; store with funct3=100 -> fault=11.
- Hold req_valid high continuously with alternating loads and stores -> accepts only in IDLE, exactly one rsp_valid per accept, correct ordering and latencies.
- Assert rst during CAPTURE of a load -> all outputs 0 immediately; after release req_ready=1 and no stale rsp_valid. Assert rst before the ISSUE edge of a store -> memory contents unchanged.
